func_call_sequencer: RTL and testbench
======================================

Name: func_call_sequencer

Overview:
- Upstream feeder for the two-operand add function unit: accepts a stream of operand pairs over valid/ready and buffers them in a DEPTH-entry FIFO.
- Issues one pair per cycle to a combinational add unit and holds the result in an output register with valid/ready backpressure.
- Sits between the operand-producing logic and the result consumer; counts completed calls for debug/coverage.

Parameters:
- WIDTH, 1, operand and result width; the result is truncated to WIDTH like the function return value.
- DEPTH, 4, operand FIFO depth; power of two, at least 2.
- CNT_W, 8, width of the completed-call counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  FIFO can accept a pair.
- in_a  in  WIDTH  first operand.
- in_b  in  WIDTH  second operand.
- out_valid  out  1  result register holds a valid result.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  (in_a + in_b) mod 2^WIDTH.
- out_carry  out  1  carry out of the WIDTH-bit add.
- call_count  out  CNT_W  completed output handshakes; saturating.
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release): FIFO pointers and level 0, in_ready=1, out_valid=0, out_sum=0, out_carry=0, call_count=0. Reset asserted mid-operation discards all buffered pairs and the held result immediately.
- Push: in_valid && in_ready at a rising edge writes {in_a,in_b} at the write pointer; the pointer wraps modulo DEPTH.
- in_ready = (fifo_level < DEPTH). At full, in_ready=0 even when a pop occurs in the same cycle; there is no combinational ready-from-pop path.
- Pop/issue: at a rising edge, when fifo_level>0 and (!out_valid || out_ready), the head pair is added and the result register loads {out_carry,out_sum}. out_valid is 1 after that edge and the read pointer advances.
- Hold: when out_valid && !out_ready, out_sum, out_carry and out_valid stay stable and no pop occurs.
- Drain: when out_valid && out_ready and the FIFO is empty, out_valid goes to 0; out_sum and out_carry keep their last values.
- Latency: a pair pushed at edge N appears on out_* after edge N+1 if the output stage is free. Throughput is one pair per cycle when out_ready stays high.
- Simultaneous push and pop when not full: fifo_level is unchanged and both pointers advance.
- Ordering: strict FIFO; results leave in the same order the pairs arrived.
- Arithmetic: the sum is computed at WIDTH+1 bits. The MSB goes to out_carry and the low WIDTH bits to out_sum.
- call_count increments on each out_valid && out_ready edge and saturates at 2^CNT_W-1.
- No X propagation: a FIFO entry is never read unless it has been written.

Decomposition:
- Package func_call_pkg holds:
  - typedef of the operand pair struct {a,b} of WIDTH;
  - the result struct {carry,sum};
  - a localparam for the level width, clog2(DEPTH)+1.
- Sub-module func_add_unit: a purely combinational WIDTH-bit adder with inputs a and b, outputs sum and carry. It mirrors the function unit so it can be swapped for other function bodies.
- The FIFO and output register stay inline in func_call_sequencer.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> in_ready=1, out_valid=0, out_sum=0, call_count=0, fifo_level=0; no push occurs.
- WIDTH=1 single call: push a=1,b=1 with out_ready=1 -> after 2 edges out_valid=1, out_sum=0, out_carry=1; the next edge gives call_count=1 and out_valid=0.
- Backpressure fill: out_ready=0, push 5 pairs (0,0),(0,1),(1,0),(1,1),(1,1):
  - first pair moves into the output register;
  - FIFO reaches 4, in_ready=0, fifo_level=4, and the 5th pair is held;
  - release out_ready -> results 0/0, 1/0, 1/0, 0/1, 0/1 (sum/carry) in order.
- Streaming at full rate, WIDTH=8: 20 random pairs with in_valid and out_ready held 1, including 200+100 -> out_sum=44, carry=1; one result per cycle after 2-cycle latency; in_ready stays 1.
- Reset mid-stream: drop rst_n asynchronously with 3 pairs buffered and out_valid=1 -> out_valid=0 and fifo_level=0 without a clock edge; after release, a new pair 3+4 yields 7.
- Saturation, CNT_W=2: complete 6 calls -> call_count reads 1,2,3,3,3,3.

Source files
------------

// File: rtl/func_call_pkg.sv
// Shared types and sizing helpers for the add-unit call sequencer.
// Holds the default operand/result bundles and the FIFO level width.
package func_call_pkg;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_DEPTH = 4;

    // Level counts 0..DEPTH inclusive, hence the extra bit.
    localparam int LEVEL_W = $clog2(DEF_DEPTH) + 1;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
    } pair_t;

    typedef struct packed {
        logic                 carry;
        logic [DEF_WIDTH-1:0] sum;
    } result_t;

    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/func_add_unit.sv
// Combinational two-operand add function body: sum = (a+b) mod 2^WIDTH.
// Ports: a, b (WIDTH) in; sum (WIDTH), carry (1) out.
module func_add_unit #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/func_call_sequencer.sv
// Operand FIFO feeding an add unit, with a registered valid/ready result.
// Ports: clk, rst_n; in_valid/in_ready/in_a/in_b; out_valid/out_ready/
// out_sum/out_carry; call_count (saturating); fifo_level (occupancy).
module func_call_sequencer
    import func_call_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_a,
    input  logic [WIDTH-1:0]              in_b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_sum,
    output logic                          out_carry,
    output logic [CNT_W-1:0]              call_count,
    output logic [level_width(DEPTH)-1:0] fifo_level
);

    localparam int LW = level_width(DEPTH);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } op_pair_t;

    op_pair_t         r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             r_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic             w_push;
    logic             w_pop;
    logic             w_fire;
    op_pair_t         w_head;
    logic [WIDTH-1:0] w_sum;
    logic             w_carry;

    // Ready depends only on the registered level, never on a same-cycle pop.
    assign in_ready = (r_level < LW'(DEPTH));
    assign w_push   = in_valid && in_ready;
    assign w_fire   = r_valid && out_ready;
    assign w_pop    = (r_level != '0) && (!r_valid || out_ready);
    assign w_head   = r_mem[r_rptr];

    func_add_unit #(.WIDTH(WIDTH)) u_add (
        .a     (w_head.a),
        .b     (w_head.b),
        .sum   (w_sum),
        .carry (w_carry)
    );

    // Storage needs no reset: an entry is only read once the level says so.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{a: in_a, b: in_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Drain clears valid only; sum/carry keep the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else if (w_pop) begin
            r_valid <= 1'b1;
            r_sum   <= w_sum;
            r_carry <= w_carry;
        end else if (w_fire) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_fire && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid  = r_valid;
    assign out_sum    = r_sum;
    assign out_carry  = r_carry;
    assign call_count = r_cnt;
    assign fifo_level = r_level;

endmodule

// File: tb/tb_func_call_sequencer.sv
// Directed bench for func_call_sequencer: a WIDTH=1 instance and a
// WIDTH=8/CNT_W=2 instance share clock and reset.
module tb_func_call_sequencer;

    logic clk;
    logic rst_n;

    logic       v1, a1, b1, or1;
    logic       rdy1, ov1, sum1, c1;
    logic [7:0] cnt1;
    logic [2:0] lvl1;

    logic       v8, or8;
    logic [7:0] a8, b8;
    logic       rdy8, ov8, c8;
    logic [7:0] sum8;
    logic [1:0] cnt8;
    logic [2:0] lvl8;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic a;
        logic b;
        logic s;
        logic c;
    } bp_vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] s;
        logic       c;
    } st_vec_t;

    bp_vec_t bp [5];
    st_vec_t st [20];

    func_call_sequencer #(.WIDTH(1), .DEPTH(4), .CNT_W(8)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (v1),
        .in_ready   (rdy1),
        .in_a       (a1),
        .in_b       (b1),
        .out_valid  (ov1),
        .out_ready  (or1),
        .out_sum    (sum1),
        .out_carry  (c1),
        .call_count (cnt1),
        .fifo_level (lvl1)
    );

    func_call_sequencer #(.WIDTH(8), .DEPTH(4), .CNT_W(2)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (v8),
        .in_ready   (rdy8),
        .in_a       (a8),
        .in_b       (b8),
        .out_valid  (ov8),
        .out_ready  (or8),
        .out_sum    (sum8),
        .out_carry  (c8),
        .call_count (cnt8),
        .fifo_level (lvl8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic set_st(input int i, input int a, input int b,
                          input int s, input logic c);
        st[i].a = 8'(a);
        st[i].b = 8'(b);
        st[i].s = 8'(s);
        st[i].c = c;
    endtask

    initial begin
        bp[0] = '{a: 1'b0, b: 1'b0, s: 1'b0, c: 1'b0};
        bp[1] = '{a: 1'b0, b: 1'b1, s: 1'b1, c: 1'b0};
        bp[2] = '{a: 1'b1, b: 1'b0, s: 1'b1, c: 1'b0};
        bp[3] = '{a: 1'b1, b: 1'b1, s: 1'b0, c: 1'b1};
        bp[4] = '{a: 1'b1, b: 1'b1, s: 1'b0, c: 1'b1};

        set_st(0,  200, 100,  44, 1'b1);
        set_st(1,    0,   0,   0, 1'b0);
        set_st(2,  255,   1,   0, 1'b1);
        set_st(3,  255, 255, 254, 1'b1);
        set_st(4,    1,   2,   3, 1'b0);
        set_st(5,  128, 128,   0, 1'b1);
        set_st(6,  127, 128, 255, 1'b0);
        set_st(7,  100,  55, 155, 1'b0);
        set_st(8,   17,  34,  51, 1'b0);
        set_st(9,  250,  10,   4, 1'b1);
        set_st(10,   3,   4,   7, 1'b0);
        set_st(11,  99,  99, 198, 1'b0);
        set_st(12,  64, 192,   0, 1'b1);
        set_st(13,  10, 245, 255, 1'b0);
        set_st(14, 200,  56,   0, 1'b1);
        set_st(15,  13, 200, 213, 1'b0);
        set_st(16,  77,  88, 165, 1'b0);
        set_st(17, 150, 150,  44, 1'b1);
        set_st(18,   1, 254, 255, 1'b0);
        set_st(19,   5, 251,   0, 1'b1);

        // Reset held with in_valid high: nothing may be pushed.
        rst_n = 1'b0;
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; or1 = 1'b0;
        v8 = 1'b0; a8 = '0; b8 = '0; or8 = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(rdy1), 1);
        check("rst_out_valid", 32'(ov1), 0);
        check("rst_out_sum", 32'(sum1), 0);
        check("rst_out_carry", 32'(c1), 0);
        check("rst_count", 32'(cnt1), 0);
        check("rst_level", 32'(lvl1), 0);
        check("rst_level8", 32'(lvl8), 0);
        v1 = 1'b0;
        rst_n = 1'b1;
        tick();

        // WIDTH=1 single call: 1+1 -> sum 0, carry 1.
        v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; or1 = 1'b1;
        tick();
        v1 = 1'b0;
        check("one_level_after_push", 32'(lvl1), 1);
        check("one_valid_early", 32'(ov1), 0);
        tick();
        check("one_valid", 32'(ov1), 1);
        check("one_sum", 32'(sum1), 0);
        check("one_carry", 32'(c1), 1);
        tick();
        check("one_count", 32'(cnt1), 1);
        check("one_drained", 32'(ov1), 0);
        check("one_drain_keeps_carry", 32'(c1), 1);

        // Backpressure fill: 5 pushes, first lands in the output register.
        or1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            v1 = 1'b1; a1 = bp[i].a; b1 = bp[i].b;
            tick();
        end
        v1 = 1'b0;
        check("bp_level_full", 32'(lvl1), 4);
        check("bp_in_ready_full", 32'(rdy1), 0);
        check("bp_out_valid", 32'(ov1), 1);
        tick();
        check("bp_hold_level", 32'(lvl1), 4);
        check("bp_hold_sum", 32'(sum1), 0);
        check("bp_hold_valid", 32'(ov1), 1);
        or1 = 1'b1;
        #1;
        check("bp_no_ready_from_pop", 32'(rdy1), 0);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_res%0d_valid", i), 32'(ov1), 1);
            check($sformatf("bp_res%0d_sum", i), 32'(sum1), 32'(bp[i].s));
            check($sformatf("bp_res%0d_carry", i), 32'(c1), 32'(bp[i].c));
            tick();
            if (i == 0) check("bp_level_after_pop", 32'(lvl1), 3);
        end
        check("bp_drained", 32'(ov1), 0);
        check("bp_level_empty", 32'(lvl1), 0);
        check("bp_count", 32'(cnt1), 6);

        // WIDTH=8 streaming at full rate.
        or8 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            v8 = 1'b1; a8 = st[i].a; b8 = st[i].b;
            #1;
            check($sformatf("st_in_ready%0d", i), 32'(rdy8), 1);
            tick();
            if (i == 0) begin
                check("st_latency_gap", 32'(ov8), 0);
            end else begin
                check($sformatf("st_res%0d", i - 1),
                      {23'd0, ov8, c8, sum8},
                      {23'd0, 1'b1, st[i-1].c, st[i-1].s});
            end
        end
        v8 = 1'b0;
        tick();
        check("st_res19", {23'd0, ov8, c8, sum8},
              {23'd0, 1'b1, st[19].c, st[19].s});
        tick();
        check("st_drained", 32'(ov8), 0);

        // Async reset mid-stream with 3 pairs buffered.
        or8 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            v8 = 1'b1; a8 = 8'(i); b8 = 8'(i);
            tick();
        end
        v8 = 1'b0;
        check("mid_level3", 32'(lvl8), 3);
        check("mid_valid", 32'(ov8), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_async_valid", 32'(ov8), 0);
        check("mid_async_level", 32'(lvl8), 0);
        tick();
        rst_n = 1'b1;
        or8 = 1'b1;
        v8 = 1'b1; a8 = 8'd3; b8 = 8'd4;
        tick();
        v8 = 1'b0;
        tick();
        check("mid_new_sum", {23'd0, ov8, c8, sum8}, {23'd0, 1'b1, 1'b0, 8'd7});
        tick();

        // Saturating counter with CNT_W=2.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            v8 = 1'b1; a8 = 8'(i); b8 = 8'd1;
            tick();
            v8 = 1'b0;
            tick();
            check($sformatf("sat_sum%0d", i), 32'(sum8), 32'(i + 1));
            tick();
            check($sformatf("sat_count%0d", i), 32'(cnt8),
                  (i < 3) ? 32'(i + 1) : 32'd3);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
